// File: rtl/uart_ctrl_pkg.sv
// uart_ctrl_pkg: shared types and defaults for the UART queue controller
package uart_ctrl_pkg;
   localparam int DATA_W_DEF = 8;
   typedef enum logic [1:0] {IDLE, START, BUSY} tx_state_t;
endpackage

// File: rtl/uart_txrx_queue_ctrl_sync_fifo.sv
// sync_fifo: first-word fall-through FIFO with wrap-bit pointers
module sync_fifo #(
   parameter int W     = 8,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     push,
   input  logic                     pop,
   input  logic [W-1:0]             din,
   output logic [W-1:0]             dout,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   level
);
   localparam int AW = $clog2(DEPTH);
   logic [W-1:0] mem [DEPTH];
   logic [AW:0]  wr_ptr, rd_ptr;
   logic         do_push, do_pop;
   assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign empty   = wr_ptr == rd_ptr;
   assign level   = wr_ptr - rd_ptr;
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   // head is masked while empty so the output reads 0 out of reset
   assign dout    = empty ? '0 : mem[rd_ptr[AW-1:0]];
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      end
   always_ff @(posedge clk)
      if (do_push) mem[wr_ptr[AW-1:0]] <= din;
endmodule

// File: rtl/uart_txrx_queue_ctrl.sv
// uart_txrx_queue_ctrl: queued glue between user logic and uart_tx/uart_rx cores
module uart_txrx_queue_ctrl
   import uart_ctrl_pkg::*;
#(
   parameter int DATA_W     = DATA_W_DEF,
   parameter int TX_DEPTH   = 4,
   parameter int RX_DEPTH   = 4,
   parameter bit CHG_DETECT = 1'b1
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic [DATA_W-1:0]           tx_data_in,
   input  logic                        tx_wr,
   input  logic                        tx_done_tick,
   output logic                        tx_start,
   output logic [DATA_W-1:0]           tx_din,
   output logic                        tx_full,
   output logic [$clog2(TX_DEPTH):0]   tx_level,
   output logic                        tx_overflow,
   input  logic                        rx_done_tick,
   input  logic [DATA_W-1:0]           rx_dout,
   input  logic                        rx_rd,
   output logic                        rx_valid,
   output logic [DATA_W-1:0]           rx_data,
   output logic [$clog2(RX_DEPTH):0]   rx_level,
   output logic                        rx_overrun,
   output logic [DATA_W-1:0]           rx_last
);
   tx_state_t         state, state_n;
   logic [DATA_W-1:0] last_q, tx_head;
   logic              enq_req, tx_pop, tx_empty, rx_full, rx_empty;
   assign enq_req  = CHG_DETECT ? (tx_data_in != last_q) : tx_wr;
   assign tx_start = state == START;
   assign rx_valid = !rx_empty;
   sync_fifo #(.W(DATA_W), .DEPTH(TX_DEPTH)) u_tx_fifo (
      .clk(clk), .reset(reset), .push(enq_req), .pop(tx_pop), .din(tx_data_in),
      .dout(tx_head), .full(tx_full), .empty(tx_empty), .level(tx_level)
   );
   sync_fifo #(.W(DATA_W), .DEPTH(RX_DEPTH)) u_rx_fifo (
      .clk(clk), .reset(reset), .push(rx_done_tick), .pop(rx_rd), .din(rx_dout),
      .dout(rx_data), .full(rx_full), .empty(rx_empty), .level(rx_level)
   );
   always_comb begin
      state_n = state;
      tx_pop  = (state == IDLE) && !tx_empty;
      if (tx_pop) state_n = START;
      else if (state == START) state_n = BUSY;
      else if (state == BUSY && tx_done_tick) state_n = IDLE;
   end
   // full is judged before the edge, so a push into a full FIFO drops even with a pop
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         state       <= IDLE;
         last_q      <= '0;
         tx_din      <= '0;
         tx_overflow <= 1'b0;
         rx_overrun  <= 1'b0;
         rx_last     <= '0;
      end else begin
         state  <= state_n;
         last_q <= tx_data_in;
         if (tx_pop) tx_din <= tx_head;
         if (enq_req && tx_full) tx_overflow <= 1'b1;
         if (rx_done_tick && rx_full) rx_overrun <= 1'b1;
         if (rx_done_tick) rx_last <= rx_dout;
      end
endmodule

// File: tb/tb_uart_txrx_queue_ctrl.sv
// tb_uart_txrx_queue_ctrl: directed + random checks against a queue-based model
module tb_uart_txrx_queue_ctrl;
   localparam int D = 4;
   int total = 0, bad = 0;
   logic clk = 1'b0, reset = 1'b1;
   always #5 clk = ~clk;
   logic [7:0] tx_data_in = '0, rx_dout = '0;
   logic       tx_wr = 1'b0, done_man = 1'b0, done_auto = 1'b0, tx_done_tick;
   logic       rx_done_tick = 1'b0, rx_rd = 1'b0;
   logic       tx_start, tx_full, tx_overflow, rx_valid, rx_overrun;
   logic [7:0] tx_din, rx_data, rx_last;
   logic [2:0] tx_level, rx_level;
   bit         auto_done = 1'b0;
   assign tx_done_tick = done_man | done_auto;
   logic [7:0] c_data = '0, c_tx_din, c_rx_data, c_rx_last;
   logic       c_done = 1'b0, c_tx_start, c_tx_full, c_tx_overflow, c_rx_valid, c_rx_overrun;
   logic [2:0] c_tx_level, c_rx_level;
   uart_txrx_queue_ctrl #(.DATA_W(8), .TX_DEPTH(D), .RX_DEPTH(D), .CHG_DETECT(1'b0)) dut (
      .clk(clk), .reset(reset), .tx_data_in(tx_data_in), .tx_wr(tx_wr),
      .tx_done_tick(tx_done_tick), .tx_start(tx_start), .tx_din(tx_din), .tx_full(tx_full),
      .tx_level(tx_level), .tx_overflow(tx_overflow), .rx_done_tick(rx_done_tick),
      .rx_dout(rx_dout), .rx_rd(rx_rd), .rx_valid(rx_valid), .rx_data(rx_data),
      .rx_level(rx_level), .rx_overrun(rx_overrun), .rx_last(rx_last)
   );
   uart_txrx_queue_ctrl #(.DATA_W(8), .TX_DEPTH(D), .RX_DEPTH(D), .CHG_DETECT(1'b1)) dut_c (
      .clk(clk), .reset(reset), .tx_data_in(c_data), .tx_wr(1'b1),
      .tx_done_tick(c_done), .tx_start(c_tx_start), .tx_din(c_tx_din), .tx_full(c_tx_full),
      .tx_level(c_tx_level), .tx_overflow(c_tx_overflow), .rx_done_tick(1'b0),
      .rx_dout(8'h00), .rx_rd(1'b0), .rx_valid(c_rx_valid), .rx_data(c_rx_data),
      .rx_level(c_rx_level), .rx_overrun(c_rx_overrun), .rx_last(c_rx_last)
   );
   logic [7:0] sent[$];
   int         c_starts = 0;
   always @(negedge clk) begin
      if (tx_start === 1'b1) sent.push_back(tx_din);
      if (c_tx_start === 1'b1) c_starts <= c_starts + 1;
   end
   // uart_tx stand-in: frame finishes 12 cycles after each start
   always begin
      @(negedge clk iff (auto_done && tx_start === 1'b1));
      repeat (11) @(posedge clk);
      #1 done_auto = 1'b1;
      @(posedge clk);
      #1 done_auto = 1'b0;
   end
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask
   task automatic step(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask
   logic [7:0] rq[$];
   logic       rovf = 1'b0;
   logic [7:0] rlast = '0;
   task automatic rx_cycle(input logic dn, input logic rd, input logic [7:0] d);
      bit was_full;
      rx_done_tick = dn;
      rx_rd = rd;
      rx_dout = d;
      step();
      rx_done_tick = 1'b0;
      rx_rd = 1'b0;
      was_full = rq.size() == D;
      if (rd && rq.size() > 0) void'(rq.pop_front());
      if (dn) begin
         rlast = d;
         if (was_full) rovf = 1'b1;
         else rq.push_back(d);
      end
      chk("rx_level", rx_level, rq.size());
      chk("rx_valid", rx_valid, rq.size() > 0);
      if (rq.size() > 0) chk("rx_head", rx_data, rq[0]);
      chk("rx_overrun", rx_overrun, rovf);
      chk("rx_last", rx_last, rlast);
   endtask
   logic [7:0] q[$], exp6[$];
   logic [7:0] v, w0, e;
   bit         ovf;
   int         n0, n;
   initial begin
      repeat (3) @(posedge clk);
      #1;
      chk("rst_tx_start", tx_start, 0);
      chk("rst_tx_din", tx_din, 0);
      chk("rst_tx_full", tx_full, 0);
      chk("rst_tx_level", tx_level, 0);
      chk("rst_tx_ovf", tx_overflow, 0);
      chk("rst_rx_valid", rx_valid, 0);
      chk("rst_rx_data", rx_data, 0);
      chk("rst_rx_level", rx_level, 0);
      chk("rst_rx_ovr", rx_overrun, 0);
      chk("rst_rx_last", rx_last, 0);
      chk("rst_c_start", c_tx_start, 0);
      reset = 1'b0;
      // change-detect: zero after reset is not a change
      step(4);
      chk("chg_hold0", c_starts, 0);
      chk("chg_level0", c_tx_level, 0);
      c_data = 8'h41;
      step();
      chk("chg_enq", c_tx_level, 1);
      chk("chg_nostart", c_tx_start, 0);
      step();
      chk("chg_start", c_tx_start, 1);
      chk("chg_din", c_tx_din, 8'h41);
      step(6);
      chk("chg_once", c_starts, 1);
      chk("chg_hold_din", c_tx_din, 8'h41);
      v = 8'($urandom_range(0, 255));
      if (v == 8'h41) v = 8'h42;
      c_done = 1'b1;
      step();
      c_done = 1'b0;
      c_data = v;
      step(2);
      chk("chg_start2", c_tx_start, 1);
      chk("chg_din2", c_tx_din, v);
      step(3);
      chk("chg_twice", c_starts, 2);
      // explicit writes while BUSY: overflow after four queued
      w0 = 8'($urandom);
      tx_data_in = w0;
      tx_wr = 1'b1;
      step();
      tx_wr = 1'b0;
      step();
      chk("t2_start0", tx_start, 1);
      chk("t2_din0", tx_din, w0);
      step();
      ovf = 1'b0;
      for (int i = 1; i <= 6; i++) begin
         tx_data_in = 8'(i);
         tx_wr = 1'b1;
         step();
         if (q.size() < D) q.push_back(8'(i));
         else ovf = 1'b1;
         chk("t2_level", tx_level, q.size());
         chk("t2_full", tx_full, q.size() == D);
      end
      tx_wr = 1'b0;
      chk("t2_ovf", tx_overflow, ovf);
      for (int k = 0; q.size() > 0; k++) begin
         done_man = 1'b1;
         step();
         done_man = 1'b0;
         chk("t2_gap", tx_start, 0);
         step();
         e = q.pop_front();
         chk("t2_start", tx_start, 1);
         chk("t2_din", tx_din, e);
         if (k == 0) done_man = 1'b1;
         step();
         done_man = 1'b0;
         step(2);
         chk("t2_busy_hold", tx_start, 0);
         chk("t2_din_held", tx_din, e);
      end
      done_man = 1'b1;
      step();
      done_man = 1'b0;
      step(2);
      chk("t2_idle", tx_start, 0);
      chk("t2_empty", tx_level, 0);
      chk("t2_ovf_sticky", tx_overflow, 1);
      chk("t2_sent_n", sent.size(), 5);
      chk("t2_sent0", sent[0], w0);
      // reset while BUSY with three words queued
      tx_data_in = 8'($urandom);
      tx_wr = 1'b1;
      step();
      tx_wr = 1'b0;
      step(2);
      for (int i = 0; i < 3; i++) begin
         tx_data_in = 8'($urandom);
         tx_wr = 1'b1;
         step();
      end
      tx_wr = 1'b0;
      chk("t5_level3", tx_level, 3);
      #2 reset = 1'b1;
      #1;
      chk("t5_start", tx_start, 0);
      chk("t5_level", tx_level, 0);
      chk("t5_ovf_clr", tx_overflow, 0);
      step();
      reset = 1'b0;
      n0 = sent.size();
      done_man = 1'b1;
      step();
      done_man = 1'b0;
      step(4);
      chk("t5_nostart", sent.size(), n0);
      // RX overrun then ordered reads
      for (int i = 0; i < 5; i++) rx_cycle(1'b1, 1'b0, 8'(8'h10 + i));
      chk("t3_level", rx_level, 4);
      chk("t3_ovr", rx_overrun, 1);
      chk("t3_last", rx_last, 8'h14);
      for (int i = 0; i < 4; i++) begin
         chk("t3_read", rx_data, 8'(8'h10 + i));
         rx_cycle(1'b0, 1'b1, 8'($urandom));
      end
      rx_cycle(1'b0, 1'b1, 8'h00);
      // simultaneous read and receive, half full and full
      rx_cycle(1'b1, 1'b0, 8'($urandom));
      rx_cycle(1'b1, 1'b0, 8'($urandom));
      rx_cycle(1'b1, 1'b1, 8'($urandom));
      chk("t4_level", rx_level, 2);
      rx_cycle(1'b1, 1'b0, 8'($urandom));
      rx_cycle(1'b1, 1'b0, 8'($urandom));
      rx_cycle(1'b1, 1'b1, 8'($urandom));
      chk("t4_full_rdwr", rx_level, 3);
      repeat (40) rx_cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 8'($urandom));
      // stream 3*DEPTH words through the wrapping pointers
      sent.delete();
      auto_done = 1'b1;
      for (int i = 0; i < 3 * D; i++) begin
         e = 8'($urandom);
         exp6.push_back(e);
         tx_data_in = e;
         tx_wr = 1'b1;
         step();
         tx_wr = 1'b0;
         if (i >= D) step(13);
      end
      n = 0;
      while (sent.size() < 3 * D && n < 400) begin
         step();
         n++;
      end
      chk("t6_count", sent.size(), 3 * D);
      for (int i = 0; i < sent.size() && i < exp6.size(); i++) chk("t6_order", sent[i], exp6[i]);
      auto_done = 1'b0;
      step(15);
      chk("t6_ovf", tx_overflow, 0);
      chk("t6_level", tx_level, 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
